// File: rtl/scratch_stack_ctrl.sv
// Address/write-control front end for the scratch RAM: stack pointer for
// PUSH/POP, direct LD/ST muxing, and a full-RAM clear sequencer.
module scratch_stack_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 10,
  parameter logic [ADDR_W-1:0] SP_INIT = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              SP_LD,
  input  logic [ADDR_W-1:0] SP_DIN,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              SCR_OP,
  input  logic              OP_WE,
  input  logic [ADDR_W-1:0] OP_ADDR,
  input  logic [DATA_W-1:0] OP_DATA,
  input  logic              CLR_START,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] DATA_IN,
  output logic [ADDR_W-1:0] SP,
  output logic              BUSY,
  output logic              CLR_DONE,
  output logic              STK_ERR
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_n;
  logic [ADDR_W-1:0] sp_q, sp_n;
  logic [ADDR_W:0]   depth, depth_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              err_q, err_n;
  logic              we;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      sp_q  <= SP_INIT;
      depth <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      sp_q  <= sp_n;
      depth <= depth_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    sp_n     = sp_q;
    depth_n  = depth;
    cnt_n    = cnt;
    err_n    = err_q;
    SCR_ADDR = OP_ADDR;
    DATA_IN  = OP_DATA;
    we       = 1'b0;
    CLR_DONE = 1'b0;
    unique case (state)
      IDLE: begin
        if (CLR_START) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else if (SP_LD) begin
          sp_n    = SP_DIN;
          depth_n = '0;
          err_n   = 1'b0;
        end else if (PUSH) begin
          SCR_ADDR = sp_q - ADDR_W'(1);
          we       = 1'b1;
          sp_n     = sp_q - ADDR_W'(1);
          // A push onto a full stack still writes but saturates depth.
          if (depth == DEPTH_MAX) err_n = 1'b1;
          else                    depth_n = depth + (ADDR_W+1)'(1);
        end else if (POP) begin
          SCR_ADDR = sp_q;
          sp_n     = sp_q + ADDR_W'(1);
          if (depth == '0) err_n = 1'b1;
          else             depth_n = depth - (ADDR_W+1)'(1);
        end else if (SCR_OP) begin
          we = OP_WE;
        end
      end
      CLEAR: begin
        SCR_ADDR = cnt;
        DATA_IN  = '0;
        we       = 1'b1;
        cnt_n    = cnt + ADDR_W'(1);
        if (cnt == '1) state_n = DONE;
      end
      DONE: begin
        CLR_DONE = 1'b1;
        sp_n     = SP_INIT;
        depth_n  = '0;
        err_n    = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign SCR_WE  = we & RST_N;
  assign SP      = sp_q;
  assign STK_ERR = err_q;
  assign BUSY    = (state != IDLE);

endmodule

// File: tb/tb_scratch_stack_ctrl.sv
// Directed self-checking bench for scratch_stack_ctrl with a behavioural
// 256x10 async-read scratch RAM hung off its outputs.
module tb_scratch_stack_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N, SP_LD, PUSH, POP, SCR_OP, OP_WE, CLR_START;
  logic [7:0] SP_DIN, OP_ADDR;
  logic [9:0] OP_DATA;
  logic [7:0] SCR_ADDR, SP;
  logic       SCR_WE, BUSY, CLR_DONE, STK_ERR;
  logic [9:0] DATA_IN;

  logic [9:0] mem [0:255];
  logic [9:0] data_out;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  scratch_stack_ctrl #(.ADDR_W(8), .DATA_W(10), .SP_INIT(8'h00)) dut (
    .CLK(CLK), .RST_N(RST_N), .SP_LD(SP_LD), .SP_DIN(SP_DIN), .PUSH(PUSH),
    .POP(POP), .SCR_OP(SCR_OP), .OP_WE(OP_WE), .OP_ADDR(OP_ADDR),
    .OP_DATA(OP_DATA), .CLR_START(CLR_START), .SCR_ADDR(SCR_ADDR),
    .SCR_WE(SCR_WE), .DATA_IN(DATA_IN), .SP(SP), .BUSY(BUSY),
    .CLR_DONE(CLR_DONE), .STK_ERR(STK_ERR)
  );

  always @(posedge CLK) if (SCR_WE) mem[SCR_ADDR] <= DATA_IN;
  assign data_out = mem[SCR_ADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    SP_LD = 0; PUSH = 0; POP = 0; SCR_OP = 0; OP_WE = 0; CLR_START = 0;
    SP_DIN = '0; OP_ADDR = '0; OP_DATA = '0;
  endtask

  task automatic do_reset();
    clr_in();
    RST_N = 0;
    cyc();
    RST_N = 1;
  endtask

  // Combinational direct LD: no clock edge needed to see DATA_OUT.
  task automatic rd(input string tag, input logic [7:0] a, input logic [9:0] exp);
    SCR_OP = 1; OP_WE = 0; OP_ADDR = a;
    #1;
    chk(tag, data_out, exp);
    SCR_OP = 0;
  endtask

  task automatic st(input logic [7:0] a, input logic [9:0] d);
    SCR_OP = 1; OP_WE = 1; OP_ADDR = a; OP_DATA = d;
    cyc();
    SCR_OP = 0; OP_WE = 0;
  endtask

  initial begin
    int n, done_at, errs_local;
    clr_in();
    RST_N = 0;
    PUSH  = 1;
    #2;
    chk("we_forced_in_reset", SCR_WE, 0);
    cyc(); cyc();
    PUSH  = 0;
    RST_N = 1;
    chk("rst_sp", SP, 8'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", CLR_DONE, 0);
    chk("rst_err", STK_ERR, 0);

    // push then pop
    PUSH = 1; OP_DATA = 10'h155;
    #1;
    chk("push_addr", SCR_ADDR, 8'hFF);
    chk("push_we", SCR_WE, 1);
    chk("push_din", DATA_IN, 10'h155);
    cyc();
    PUSH = 0;
    chk("push_sp", SP, 8'hFF);
    POP = 1;
    #1;
    chk("pop_addr", SCR_ADDR, 8'hFF);
    chk("pop_we", SCR_WE, 0);
    chk("pop_data", data_out, 10'h155);
    cyc();
    POP = 0;
    chk("pop_sp", SP, 8'h00);
    chk("pop_err", STK_ERR, 0);

    // underflow, then SP_LD clears error
    do_reset();
    POP = 1;
    #1;
    chk("uf_addr", SCR_ADDR, 8'h00);
    cyc();
    POP = 0;
    chk("uf_sp", SP, 8'h01);
    chk("uf_err", STK_ERR, 1);
    SP_LD = 1; SP_DIN = 8'h80;
    cyc();
    SP_LD = 0;
    chk("ld_sp", SP, 8'h80);
    chk("ld_err", STK_ERR, 0);

    // fill the stack to 256, then overflow
    do_reset();
    for (int i = 0; i < 256; i++) begin
      PUSH = 1; OP_DATA = 10'(i);
      cyc();
    end
    PUSH = 0;
    chk("full_err", STK_ERR, 0);
    chk("full_sp", SP, 8'h00);
    errs_local = fails;
    for (int i = 0; i < 256; i++) rd("full_rd", 8'(255 - i), 10'(i));
    PUSH = 1; OP_DATA = 10'h2AA;
    #1;
    chk("of_addr", SCR_ADDR, 8'hFF);
    chk("of_we", SCR_WE, 1);
    cyc();
    PUSH = 0;
    chk("of_err", STK_ERR, 1);
    chk("of_sp", SP, 8'hFF);
    rd("of_rd", 8'hFF, 10'h2AA);

    // direct ST / LD
    SP_LD = 1; SP_DIN = 8'h10;
    cyc();
    SP_LD = 0;
    st(8'h42, 10'h3AA);
    rd("ld_42", 8'h42, 10'h3AA);
    chk("direct_sp", SP, 8'h10);

    // priority: PUSH beats POP
    PUSH = 1; POP = 1; OP_DATA = 10'h011;
    #1;
    chk("pp_we", SCR_WE, 1);
    chk("pp_addr", SCR_ADDR, 8'h0F);
    cyc();
    PUSH = 0; POP = 0;
    chk("pp_sp", SP, 8'h0F);
    rd("pp_rd", 8'h0F, 10'h011);
    // priority: SP_LD beats PUSH, no write
    SP_LD = 1; SP_DIN = 8'h20; PUSH = 1; OP_DATA = 10'h099;
    #1;
    chk("lp_we", SCR_WE, 0);
    cyc();
    SP_LD = 0; PUSH = 0;
    chk("lp_sp", SP, 8'h20);
    rd("lp_rd", 8'h1F, 10'h0E0);

    // full clear with a PUSH held throughout
    for (int i = 0; i < 256; i++) st(8'(i), 10'h0FC);
    SP_LD = 1; SP_DIN = 8'h33;
    cyc();
    SP_LD = 0;
    CLR_START = 1; PUSH = 1; OP_DATA = 10'h123;
    cyc();
    CLR_START = 0;
    n = 0; done_at = -1; errs_local = 0;
    while (BUSY && n < 300) begin
      if (CLR_DONE) begin
        if (done_at < 0) done_at = n; else errs_local++;
        PUSH = 0;
      end
      if (n == 10) chk("clr_sp_hold", SP, 8'h33);
      n++;
      cyc();
    end
    PUSH = 0;
    chk("clr_busy_len", n, 257);
    chk("clr_done_at", done_at, 256);
    chk("clr_done_extra", errs_local, 0);
    chk("clr_sp", SP, 8'h00);
    chk("clr_done_low", CLR_DONE, 0);
    for (int i = 0; i < 256; i++) rd("clr_rd", 8'(i), 10'h000);

    // reset aborts a clear after 100 writes
    for (int i = 0; i < 256; i++) st(8'(i), 10'h0FC);
    CLR_START = 1;
    cyc();
    CLR_START = 0;
    for (int i = 0; i < 100; i++) cyc();
    RST_N = 0;
    #1;
    chk("abort_we", SCR_WE, 0);
    cyc();
    RST_N = 1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", CLR_DONE, 0);
    for (int i = 0; i < 256; i++)
      rd("abort_rd", 8'(i), (i < 100) ? 10'h000 : 10'h0FC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scratch_stack_ctrl.md
# scratch_stack_ctrl

Address/write-control front end for the 256x10 `Scratch_RAM`, sitting directly upstream of it and driving its `SCR_ADDR`, `SCR_WE` and `DATA_IN` pins. The block owns the stack pointer for PUSH/POP and muxes direct LD/ST accesses from the control unit. It also runs a 256-cycle clear sequencer that zeroes the whole RAM. Read data returns straight from the RAM's `DATA_OUT`; this block never registers it.

## Interface
- `ADDR_W`, 8, scratch address width (RAM depth = 2^ADDR_W)
- `DATA_W`, 10, scratch data width
- `SP_INIT`, 0, stack pointer value after reset, SP_LD-free clear, or clear completion

- `CLK`  in  1  system clock, all state updates on rising edge
- `RST_N`  in  1  synchronous, active-low reset
- `SP_LD`  in  1  load SP from `SP_DIN`
- `SP_DIN`  in  ADDR_W  new SP value
- `PUSH`  in  1  push `OP_DATA`
- `POP`  in  1  pop; data appears on RAM `DATA_OUT` same cycle
- `SCR_OP`  in  1  direct access at `OP_ADDR`
- `OP_WE`  in  1  direct access is a write (qualifies `SCR_OP`)
- `OP_ADDR`  in  ADDR_W  direct access address
- `OP_DATA`  in  DATA_W  write data for PUSH and direct write
- `CLR_START`  in  1  start full-RAM clear
- `SCR_ADDR`  out  ADDR_W  to RAM address
- `SCR_WE`  out  1  to RAM write enable
- `DATA_IN`  out  DATA_W  to RAM write data
- `SP`  out  ADDR_W  current stack pointer
- `BUSY`  out  1  clear in progress; commands ignored
- `CLR_DONE`  out  1  one-cycle pulse at clear completion
- `STK_ERR`  out  1  sticky overflow/underflow flag

## Operation
- Registers: `SP` (ADDR_W), `depth` (ADDR_W+1, 0..256), clear counter `cnt` (ADDR_W), state {IDLE, CLEAR, DONE}, `STK_ERR`.
- IDLE command priority, one command per cycle: SP_LD > PUSH > POP > SCR_OP. Lower-priority commands in the same cycle are dropped with no effect.
- SP_LD: SP <= SP_DIN, depth <= 0, STK_ERR <= 0. No RAM write.
- PUSH: SCR_ADDR = SP-1 (mod 2^ADDR_W), SCR_WE = 1, DATA_IN = OP_DATA. Then SP <= SP-1 and depth <= depth+1. If depth == 256 before the push, STK_ERR <= 1, the write still happens, and depth stays 256.
- POP: SCR_ADDR = SP, SCR_WE = 0. Then SP <= SP+1 (wraps 255->0) and depth <= depth-1. If depth == 0 before the pop, STK_ERR <= 1, SP still increments, and depth stays 0.
- SCR_OP: SCR_ADDR = OP_ADDR, SCR_WE = OP_WE, DATA_IN = OP_DATA. SP is unchanged.
- No command: SCR_ADDR = OP_ADDR, SCR_WE = 0, DATA_IN = OP_DATA.
- IDLE -> CLEAR on CLR_START, with cnt <= 0. CLR_START has priority over all other commands in that cycle; those commands are dropped.
- CLEAR: SCR_ADDR = cnt, SCR_WE = 1, DATA_IN = 0, cnt <= cnt+1. At cnt == 255 go to DONE.
- DONE: SCR_WE = 0, CLR_DONE = 1, SP <= SP_INIT, depth <= 0, STK_ERR <= 0. Then go to IDLE unconditionally.
- BUSY = (state != IDLE). While BUSY, all command inputs, including CLR_START, are ignored.
- STK_ERR is cleared only by reset, SP_LD, or DONE.

## Timing
- Address, write-enable and data outputs are combinational from inputs and state. The RAM write commits on the same rising edge that updates SP.
- Pop data is valid on RAM `DATA_OUT` during the POP cycle (asynchronous RAM read). The SP increment is visible the following cycle.
- Clear: the edge sampling CLR_START enters CLEAR. 256 write cycles follow, then 1 DONE cycle. BUSY is high for 257 cycles; CLR_DONE is high only in cycle 257.
- Reset (RST_N = 0 at an edge), next-cycle values: SP = SP_INIT, depth = 0, state = IDLE, STK_ERR = 0, BUSY = 0, CLR_DONE = 0.
- SCR_WE is forced to 0 combinationally whenever RST_N = 0.
- Reset mid-clear aborts to IDLE. RAM contents already written stay written, and no CLR_DONE pulse is produced.

## Test plan
- Reset, then PUSH 0x155: RAM write at addr 0xFF with data 0x155, SP = 0xFF. POP in the next cycle: SCR_ADDR = 0xFF, DATA_OUT = 0x155, then SP = 0x00, STK_ERR = 0.
- POP right after reset -> SCR_ADDR = 0x00, SP becomes 0x01, STK_ERR = 1. SP_LD 0x80 -> SP = 0x80, STK_ERR = 0.
- 256 PUSHes of the index value i -> addr 0xFF-i holds i, STK_ERR = 0. The 257th PUSH -> STK_ERR = 1, write lands at addr 0xFF.
- Direct ST (SCR_OP = 1, OP_WE = 1) of 0x3AA to addr 0x42, then direct LD of 0x42 -> DATA_OUT = 0x3AA, SP unchanged.
- Priority: PUSH+POP together -> only the push occurs. SP_LD+PUSH -> only the load occurs, no RAM write.
- Fill RAM with 0xFC, then CLR_START:
  - BUSY high 257 cycles; CLR_DONE pulses once; PUSH during BUSY ignored.
  - Afterwards all 256 addresses read 0, SP = SP_INIT.
  - RST_N low at clear cycle 100 -> addresses 0..99 read 0, the rest read 0xFC, BUSY = 0.
